// File: rtl/uart_tx.sv
// 8N1 asynchronous serial transmitter with load-strobe byte handover.
// Frame is start bit, eight data bits LSB first, stop bit; each bit lasts CLKS_PER_BIT clocks.
module uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] in,
    output logic       tx,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TIMER_TC  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] TIMER_ONE = CW'(1);
    localparam logic [CW-1:0] TIMER_ZERO = CW'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] timer_r;
    logic [CW-1:0] timer_next_s;
    logic [2:0]    index_r;
    logic [2:0]    index_next_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_next_s;
    logic          tx_r;
    logic          tx_next_s;
    logic          busy_r;
    logic          busy_next_s;
    logic          timer_done_s;

    assign timer_done_s = (timer_r == TIMER_TC);

    // State, datapath and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            timer_r <= TIMER_ZERO;
            index_r <= 3'd0;
            shift_r <= 8'd0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
            index_r <= index_next_s;
            shift_r <= shift_next_s;
            tx_r    <= tx_next_s;
            busy_r  <= busy_next_s;
        end
    end

    // Next-state logic; tx/busy are computed for the upcoming cycle so the outputs stay registered.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        index_next_s = index_r;
        shift_next_s = shift_r;
        tx_next_s    = 1'b1;
        busy_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (load) begin
                    state_next_s = START;
                    shift_next_s = in;
                    timer_next_s = TIMER_ZERO;
                    index_next_s = 3'd0;
                    tx_next_s    = 1'b0;
                    busy_next_s  = 1'b1;
                end else begin
                    tx_next_s    = 1'b1;
                    busy_next_s  = 1'b0;
                end
            end
            START: begin
                busy_next_s = 1'b1;
                if (timer_done_s) begin
                    state_next_s = DATA;
                    timer_next_s = TIMER_ZERO;
                    index_next_s = 3'd0;
                    tx_next_s    = shift_r[0];
                end else begin
                    timer_next_s = timer_r + TIMER_ONE;
                    tx_next_s    = 1'b0;
                end
            end
            DATA: begin
                busy_next_s = 1'b1;
                if (timer_done_s) begin
                    timer_next_s = TIMER_ZERO;
                    if (index_r == 3'd7) begin
                        state_next_s = STOP;
                        tx_next_s    = 1'b1;
                    end else begin
                        index_next_s = index_r + 3'd1;
                        tx_next_s    = shift_r[index_r + 3'd1];
                    end
                end else begin
                    timer_next_s = timer_r + TIMER_ONE;
                    tx_next_s    = shift_r[index_r];
                end
            end
            STOP: begin
                tx_next_s = 1'b1;
                if (timer_done_s) begin
                    // Always pass through one IDLE cycle so busy drops between frames.
                    state_next_s = IDLE;
                    timer_next_s = TIMER_ZERO;
                    busy_next_s  = 1'b0;
                end else begin
                    timer_next_s = timer_r + TIMER_ONE;
                    busy_next_s  = 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
                timer_next_s = TIMER_ZERO;
                index_next_s = 3'd0;
                tx_next_s    = 1'b1;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    assign tx   = tx_r;
    assign busy = busy_r;

endmodule
